// File: rtl/alu_pkg.sv
// Shared encodings for the execute-stage ALU: operation codes, result-source
// selects and condition-code register bit positions.
package alu_pkg;

  localparam logic [3:0] ALU_NOP  = 4'b0000;
  localparam logic [3:0] ALU_MOV  = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0011;
  localparam logic [3:0] ALU_AND  = 4'b0100;
  localparam logic [3:0] ALU_OR   = 4'b0101;
  localparam logic [3:0] ALU_RLC  = 4'b0110;
  localparam logic [3:0] ALU_RRC  = 4'b0111;
  localparam logic [3:0] ALU_SETC = 4'b1000;
  localparam logic [3:0] ALU_CLRC = 4'b1001;
  localparam logic [3:0] ALU_NOT  = 4'b1010;
  localparam logic [3:0] ALU_NEG  = 4'b1011;
  localparam logic [3:0] ALU_INC  = 4'b1100;
  localparam logic [3:0] ALU_DEC  = 4'b1101;

  localparam logic [1:0] SE3_ALU = 2'b00;
  localparam logic [1:0] SE3_B   = 2'b10;

  localparam int CCR_Z = 0;
  localparam int CCR_N = 1;
  localparam int CCR_C = 2;
  localparam int CCR_V = 3;

  // NOP and the reserved codes never touch the CCR.
  function automatic logic writes_flags(input logic [3:0] code);
    return !(code == ALU_NOP || code == 4'b1110 || code == 4'b1111);
  endfunction

endpackage

// File: rtl/alu_exec_stage_if.sv
// Decode-to-execute bus: decoded control, operands, CCR restore, and the
// registered result/flags returned toward the memory stage.
interface alu_exec_stage_if #(parameter int WIDTH = 8);

  logic             in_valid;
  logic             stall;
  logic             flush;
  logic [3:0]       alu_control;
  logic             se1;
  logic             se2;
  logic [1:0]       se3;
  logic [WIDTH-1:0] a_data;
  logic [WIDTH-1:0] b_data;
  logic             flags_load;
  logic [3:0]       flags_in;
  logic             out_valid;
  logic [WIDTH-1:0] result;
  logic [3:0]       flags;

  modport master (
    output in_valid, stall, flush, alu_control, se1, se2, se3,
           a_data, b_data, flags_load, flags_in,
    input  out_valid, result, flags
  );

  modport slave (
    input  in_valid, stall, flush, alu_control, se1, se2, se3,
           a_data, b_data, flags_load, flags_in,
    output out_valid, result, flags
  );

endinterface

// File: rtl/alu_core.sv
// Combinational ALU: result plus candidate {V,C,N,Z} for the CCR.
// Ops that do not define C pass c_in through as their candidate.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [3:0]       alu_control,
  input  logic [WIDTH-1:0] a_data,
  input  logic [WIDTH-1:0] b_data,
  input  logic             c_in,
  output logic [WIDTH-1:0] alu_res,
  output logic [3:0]       cand_flags,
  output logic             flag_upd,
  output logic             c_force
);

  localparam int MSB = WIDTH - 1;
  localparam logic [WIDTH:0] ONE_W = (WIDTH+1)'(1);

  logic [WIDTH:0] ext_a;
  logic [WIDTH:0] ext_b;
  logic [WIDTH:0] wide;
  logic           c_out;
  logic           v_out;

  assign ext_a = {1'b0, a_data};
  assign ext_b = {1'b0, b_data};

  always_comb begin
    wide     = '0;
    alu_res  = '0;
    c_out    = c_in;
    v_out    = 1'b0;
    flag_upd = writes_flags(alu_control);
    c_force  = 1'b0;
    case (alu_control)
      ALU_MOV: alu_res = b_data;
      ALU_ADD: begin
        wide    = ext_a + ext_b;
        alu_res = wide[MSB:0];
        c_out   = wide[WIDTH];
        v_out   = (a_data[MSB] == b_data[MSB]) && (alu_res[MSB] != a_data[MSB]);
      end
      ALU_SUB: begin
        // Bit WIDTH of the widened difference is the borrow.
        wide    = ext_a - ext_b;
        alu_res = wide[MSB:0];
        c_out   = wide[WIDTH];
        v_out   = (a_data[MSB] != b_data[MSB]) && (alu_res[MSB] != a_data[MSB]);
      end
      ALU_AND: alu_res = a_data & b_data;
      ALU_OR:  alu_res = a_data | b_data;
      ALU_RLC: begin
        alu_res = {b_data[MSB-1:0], c_in};
        c_out   = b_data[MSB];
      end
      ALU_RRC: begin
        alu_res = {c_in, b_data[MSB:1]};
        c_out   = b_data[0];
      end
      ALU_SETC: begin
        c_out   = 1'b1;
        c_force = 1'b1;
      end
      ALU_CLRC: begin
        c_out   = 1'b0;
        c_force = 1'b1;
      end
      ALU_NOT: alu_res = ~b_data;
      ALU_NEG: begin
        wide    = '0 - ext_b;
        alu_res = wide[MSB:0];
        c_out   = wide[WIDTH];
      end
      ALU_INC: begin
        wide    = ext_b + ONE_W;
        alu_res = wide[MSB:0];
        c_out   = wide[WIDTH];
      end
      ALU_DEC: begin
        wide    = ext_b - ONE_W;
        alu_res = wide[MSB:0];
        c_out   = wide[WIDTH];
      end
      default: alu_res = '0;
    endcase
  end

  assign cand_flags[CCR_Z] = (alu_res == '0);
  assign cand_flags[CCR_N] = alu_res[MSB];
  assign cand_flags[CCR_C] = c_out;
  assign cand_flags[CCR_V] = v_out;

endmodule

// File: rtl/alu_exec_stage.sv
// Execute stage: wraps alu_core with per-bit CCR write enables, the result
// pipeline register and stall/flush/CCR-restore control.
module alu_exec_stage
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  alu_exec_stage_if.slave  bus
);

  logic [WIDTH-1:0] alu_res;
  logic [3:0]       cand_flags;
  logic             flag_upd;
  logic             c_force;
  logic             accepted;
  logic [3:0]       wr_en;
  logic [3:0]       flags_upd;

  logic             out_valid_reg, out_valid_next;
  logic [WIDTH-1:0] result_reg, result_next;
  logic [3:0]       flags_reg, flags_next;

  alu_core #(.WIDTH(WIDTH)) u_core (
    .alu_control (bus.alu_control),
    .a_data      (bus.a_data),
    .b_data      (bus.b_data),
    .c_in        (flags_reg[CCR_C]),
    .alu_res     (alu_res),
    .cand_flags  (cand_flags),
    .flag_upd    (flag_upd),
    .c_force     (c_force)
  );

  assign accepted = bus.in_valid && !bus.stall && !bus.flush;

  // SETC/CLRC own the carry regardless of se2.
  assign wr_en[CCR_Z] = accepted && flag_upd && bus.se1;
  assign wr_en[CCR_N] = accepted && flag_upd && bus.se1;
  assign wr_en[CCR_V] = accepted && flag_upd && bus.se1;
  assign wr_en[CCR_C] = accepted && ((flag_upd && bus.se2) || c_force);

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_ccr_bit
      assign flags_upd[gi] = wr_en[gi] ? cand_flags[gi] : flags_reg[gi];
    end
  endgenerate

  always_comb begin
    out_valid_next = bus.in_valid && !bus.flush;
    result_next    = result_reg;
    if (accepted)
      result_next = (bus.se3 == SE3_B) ? bus.b_data : alu_res;
    // An RTI restore wins over any flag write on the same edge.
    flags_next = bus.flags_load ? bus.flags_in : flags_upd;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_reg <= 1'b0;
      result_reg    <= '0;
      flags_reg     <= 4'b0000;
    end else if (!bus.stall) begin
      out_valid_reg <= out_valid_next;
      result_reg    <= result_next;
      flags_reg     <= flags_next;
    end
  end

  assign bus.out_valid = out_valid_reg;
  assign bus.result    = result_reg;
  assign bus.flags     = flags_reg;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed bench for alu_exec_stage: hand-computed result/valid/CCR after each edge.
module tb_alu_exec_stage;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  alu_exec_stage_if #(.WIDTH(8)) bus ();

  alu_exec_stage #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic ov, input logic [7:0] res,
                            input logic [3:0] fl);
    $display("txn %s: out_valid=%0b result=%02h flags=%04b", tag, bus.out_valid,
             bus.result, bus.flags);
    chk({tag, ".ov"},    32'(bus.out_valid), 32'(ov));
    chk({tag, ".res"},   32'(bus.result),    32'(res));
    chk({tag, ".flags"}, 32'(bus.flags),     32'(fl));
  endtask

  // Apply one set of inputs across a rising edge, then settle past it.
  task automatic step(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                      input logic s1, input logic s2, input logic [1:0] s3,
                      input logic v, input logic st, input logic fl,
                      input logic ld, input logic [3:0] fin);
    bus.alu_control = op;
    bus.a_data      = a;
    bus.b_data      = b;
    bus.se1         = s1;
    bus.se2         = s2;
    bus.se3         = s3;
    bus.in_valid    = v;
    bus.stall       = st;
    bus.flush       = fl;
    bus.flags_load  = ld;
    bus.flags_in    = fin;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    bus.alu_control = ALU_NOP;
    bus.a_data = '0;
    bus.b_data = '0;
    bus.se1 = 1'b0;
    bus.se2 = 1'b0;
    bus.se3 = SE3_ALU;
    bus.in_valid = 1'b0;
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    bus.flags_load = 1'b0;
    bus.flags_in = 4'b0000;

    step(ALU_NOP, 8'h00, 8'h00, 0, 0, SE3_ALU, 0, 0, 0, 0, 4'h0);
    step(ALU_NOP, 8'h00, 8'h00, 0, 0, SE3_ALU, 0, 0, 0, 0, 4'h0);
    expect_out("reset", 1'b0, 8'h00, 4'b0000);
    rst = 1'b0;

    step(ALU_ADD, 8'hFF, 8'h01, 1, 1, SE3_ALU, 1, 0, 0, 0, 4'h0);
    expect_out("add_carry_zero", 1'b1, 8'h00, 4'b0101);
    step(ALU_SUB, 8'h7F, 8'hFF, 1, 1, SE3_ALU, 1, 0, 0, 0, 4'h0);
    expect_out("sub_ovf_borrow", 1'b1, 8'h80, 4'b1110);
    step(ALU_NOP, 8'h12, 8'h34, 1, 1, SE3_ALU, 1, 0, 0, 0, 4'h0);
    expect_out("nop", 1'b1, 8'h00, 4'b1110);
    step(ALU_CLRC, 8'h00, 8'h00, 0, 0, SE3_ALU, 1, 0, 0, 0, 4'h0);
    expect_out("clrc", 1'b1, 8'h00, 4'b1010);
    step(ALU_SETC, 8'h00, 8'h00, 0, 0, SE3_ALU, 1, 0, 0, 0, 4'h0);
    expect_out("setc", 1'b1, 8'h00, 4'b1110);
    step(ALU_RLC, 8'h00, 8'h80, 1, 1, SE3_ALU, 1, 0, 0, 0, 4'h0);
    expect_out("rlc", 1'b1, 8'h01, 4'b0100);
    step(ALU_CLRC, 8'h00, 8'h00, 0, 0, SE3_ALU, 1, 0, 0, 0, 4'h0);
    expect_out("clrc2", 1'b1, 8'h00, 4'b0000);
    step(ALU_RRC, 8'h00, 8'h01, 1, 1, SE3_ALU, 1, 0, 0, 0, 4'h0);
    expect_out("rrc", 1'b1, 8'h00, 4'b0101);
    step(ALU_MOV, 8'h00, 8'h5A, 0, 0, SE3_B, 1, 0, 0, 0, 4'h0);
    expect_out("mov_b", 1'b1, 8'h5A, 4'b0101);
    step(ALU_ADD, 8'h01, 8'h02, 1, 1, SE3_B, 1, 0, 0, 0, 4'h0);
    expect_out("se3_b_flags_alu", 1'b1, 8'h02, 4'b0000);
    step(ALU_AND, 8'h0F, 8'h3C, 1, 1, SE3_ALU, 1, 0, 0, 0, 4'h0);
    expect_out("and", 1'b1, 8'h0C, 4'b0000);
    step(ALU_OR, 8'h80, 8'h01, 1, 0, SE3_ALU, 1, 0, 0, 0, 4'h0);
    expect_out("or", 1'b1, 8'h81, 4'b0010);
    step(ALU_NOT, 8'h00, 8'hFF, 1, 0, SE3_ALU, 1, 0, 0, 0, 4'h0);
    expect_out("not", 1'b1, 8'h00, 4'b0001);
    step(ALU_ADD, 8'h7F, 8'h01, 1, 1, SE3_ALU, 1, 0, 0, 0, 4'h0);
    expect_out("add_ovf", 1'b1, 8'h80, 4'b1010);
    step(ALU_INC, 8'h00, 8'hFF, 1, 1, SE3_ALU, 1, 0, 0, 0, 4'h0);
    expect_out("inc_wrap", 1'b1, 8'h00, 4'b0101);
    step(ALU_NEG, 8'h00, 8'h00, 1, 1, SE3_ALU, 1, 0, 0, 0, 4'h0);
    expect_out("neg_zero", 1'b1, 8'h00, 4'b0001);
    step(ALU_DEC, 8'h00, 8'h00, 1, 1, SE3_ALU, 1, 0, 0, 0, 4'h0);
    expect_out("dec_borrow", 1'b1, 8'hFF, 4'b0110);

    for (int i = 0; i < 2; i++) begin
      step(ALU_ADD, 8'h10, 8'h20, 1, 1, SE3_ALU, 1, 1, 1, 1, 4'b1111);
      expect_out($sformatf("stall%0d", i), 1'b1, 8'hFF, 4'b0110);
    end
    step(ALU_ADD, 8'h10, 8'h20, 1, 1, SE3_ALU, 1, 0, 1, 1, 4'b1010);
    expect_out("flush_load", 1'b0, 8'hFF, 4'b1010);
    step(ALU_ADD, 8'h10, 8'h20, 1, 1, SE3_ALU, 0, 0, 0, 0, 4'h0);
    expect_out("idle", 1'b0, 8'hFF, 4'b1010);
    step(ALU_DEC, 8'h00, 8'h10, 1, 1, SE3_ALU, 1, 0, 0, 1, 4'b0011);
    expect_out("dec_load", 1'b1, 8'h0F, 4'b0011);

    rst = 1'b1;
    step(ALU_ADD, 8'h55, 8'h66, 1, 1, SE3_ALU, 1, 1, 0, 1, 4'b1111);
    expect_out("mid_reset", 1'b0, 8'h00, 4'b0000);
    rst = 1'b0;
    step(ALU_ADD, 8'h03, 8'h04, 1, 1, SE3_ALU, 1, 0, 0, 0, 4'h0);
    expect_out("after_reset", 1'b1, 8'h07, 4'b0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
